// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display slice.
// Holds the arbiter state encoding, the requester count, the frame-rate
// constant used by the display block, and small mux/decode helpers.
package display_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int DISP_NUM_REQ = 4;
    localparam int FRAMERATE    = 60;

    // One-hot decode of a 2-bit requester index.
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Select the 16-bit value slice belonging to requester idx.
    function automatic logic [15:0] select_value(input logic [63:0] vals,
                                                 input logic [1:0]  idx);
        logic [15:0] v;
        case (idx)
            2'd0:    v = vals[15:0];
            2'd1:    v = vals[31:16];
            2'd2:    v = vals[47:32];
            2'd3:    v = vals[63:48];
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_select.sv
// Combinational round-robin picker.
// Scans requesters starting one past last_i (wrapping 3->0) and returns the
// first set request. When exclude_en_i is high, index exclude_i is skipped.
//   req_i        requests, one bit per source
//   last_i       most recently granted index
//   exclude_en_i enable skipping of exclude_i
//   exclude_i    index to skip
//   pick_o       chosen index (0 when nothing valid)
//   pick_valid_o a requester was found
module rr_select
    import display_pkg::*;
(
    input  logic [DISP_NUM_REQ-1:0] req_i,
    input  logic [1:0]              last_i,
    input  logic                    exclude_en_i,
    input  logic [1:0]              exclude_i,
    output logic [1:0]              pick_o,
    output logic                    pick_valid_o
);

    logic [1:0] cand_s;

    // Priority scan last+1 .. last+4; the 2-bit add provides the wrap.
    always_comb begin
        pick_o       = 2'd0;
        pick_valid_o = 1'b0;
        cand_s       = 2'd0;
        for (int k = 1; k <= DISP_NUM_REQ; k++) begin
            cand_s = last_i + 2'(k);
            if (!pick_valid_o && req_i[cand_s] &&
                !(exclude_en_i && (cand_s == exclude_i))) begin
                pick_o       = cand_s;
                pick_valid_o = 1'b1;
            end else begin
                pick_o       = pick_o;
                pick_valid_o = pick_valid_o;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between four
// requesters, with a guaranteed minimum dwell per grant.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        level-sensitive request per source
//   req_value_i  source i value on bits [16i+15:16i]
//   grant_o      one-hot current owner, 0 when idle (registered)
//   value_o      value for the display block (registered, one-cycle lag)
//   busy_o       high while a grant is active (registered)
module display_arbiter
    import display_pkg::*;
#(
    parameter int          CLOCK_SPEED = 12_000_000,
    parameter int          HOLD_MS     = 1000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DISP_NUM_REQ-1:0]    req_i,
    input  logic [16*DISP_NUM_REQ-1:0] req_value_i,
    output logic [DISP_NUM_REQ-1:0]    grant_o,
    output logic [15:0]                value_o,
    output logic                       busy_o
);

    localparam int HOLD_CYCLES = CLOCK_SPEED / 1000 * HOLD_MS;
    localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    state_e                  state_q, state_d;
    logic [1:0]              last_q,  last_d;
    logic [CNT_W-1:0]        hold_q,  hold_d;
    logic [DISP_NUM_REQ-1:0] grant_q, grant_d;
    logic [15:0]             value_q, value_d;
    logic                    busy_q,  busy_d;

    logic [1:0] pick_s;
    logic       pick_valid_s;

    // While holding, the owner (== last_q) is last in rotation and is excluded,
    // so a pick during HOLD always names a different source.
    rr_select u_rr_select (
        .req_i        (req_i),
        .last_i       (last_q),
        .exclude_en_i (state_q == ST_HOLD),
        .exclude_i    (last_q),
        .pick_o       (pick_s),
        .pick_valid_o (pick_valid_s)
    );

    // Next-state, dwell counter and registered output computation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_HOLD;
                    last_d  = pick_s;
                    hold_d  = HOLD_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Release wins over expiry when both happen in one cycle.
                if (!req_i[last_q]) begin
                    if (pick_valid_s) begin
                        last_d = pick_s;
                        hold_d = HOLD_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = CNT_ZERO;
                    end
                end else if (hold_q != CNT_ZERO) begin
                    hold_d = hold_q - CNT_ONE;
                end else begin
                    // Dwell expired: hand over if anyone else waits, else keep.
                    if (pick_valid_s) begin
                        last_d = pick_s;
                    end else begin
                        last_d = last_q;
                    end
                    hold_d = HOLD_RELOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 2'd3;
                hold_d  = CNT_ZERO;
            end
        endcase

        if (state_d == ST_HOLD) begin
            grant_d = idx_to_onehot(last_d);
            busy_d  = 1'b1;
        end else begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
        end

        // Value follows the owner registered this cycle, hence the one-cycle lag.
        if (state_q == ST_HOLD) begin
            value_d = select_value(req_value_i, last_q);
        end else begin
            value_d = IDLE_VALUE;
        end
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            hold_q  <= CNT_ZERO;
            grant_q <= 4'b0000;
            value_q <= IDLE_VALUE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            value_q <= value_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_o = grant_q;
    assign value_o = value_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with HOLD_CYCLES = 4.
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [63:0] req_value = 64'h0;
    logic [3:0]  grant_o;
    logic [15:0] value_o;
    logic        busy_o;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: owner index (-1 idle), last grant, dwell left.
    int          m_owner;
    int          m_last;
    int          m_cnt;
    logic [3:0]  exp_grant;
    logic [15:0] exp_value;
    logic        exp_busy;

    display_arbiter #(
        .CLOCK_SPEED (4000),
        .HOLD_MS     (1),
        .IDLE_VALUE  (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_value_i (req_value),
        .grant_o     (grant_o),
        .value_o     (value_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] r, input int after, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (after + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_cnt = 0;
        exp_grant = 4'b0000; exp_value = 16'h0000; exp_busy = 1'b0;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        int p;
        exp_value = (m_owner >= 0) ? req_value[16*m_owner +: 16] : 16'h0000;
        if (m_owner < 0) begin
            p = rr_pick(req, m_last, -1);
            if (p >= 0) begin m_owner = p; m_last = p; m_cnt = HOLD - 1; end
        end else if (!req[m_owner]) begin
            p = rr_pick(req, m_owner, m_owner);
            if (p >= 0) begin m_owner = p; m_last = p; m_cnt = HOLD - 1; end
            else m_owner = -1;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end else begin
            p = rr_pick(req, m_owner, m_owner);
            if (p >= 0) begin m_owner = p; m_last = p; end
            m_cnt = HOLD - 1;
        end
        exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        exp_busy  = (m_owner >= 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        req_value = 64'h4444_3333_2222_1111;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_vec++;
        if ({grant_o, busy_o, value_o} !== {4'b0000, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: grant/busy/value got %b/%b/%h want 0000/0/0000", grant_o, busy_o, value_o);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant got %b want 0001", grant_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        req_value = 64'h0000_BEEF_0000_0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if ({grant_o, busy_o, value_o} !== {exp_grant, exp_busy, exp_value}) begin
                n_fail++;
                $display("FAIL single[%0d]: grant/busy/value got %b/%b/%h want %b/%b/%h", i, grant_o, busy_o, value_o, exp_grant, exp_busy, exp_value);
            end
            if (i >= 1) begin
                n_vec++;
                if ({grant_o, value_o} !== {4'b0100, 16'hBEEF}) begin
                    n_fail++;
                    $display("FAIL single_const[%0d]: grant/value got %b/%h want 0100/beef", i, grant_o, value_o);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            req_value = {$urandom, $urandom};
            tick();
            want = 4'b0001 << (((c - 1) / HOLD) % 4);
            n_vec++;
            if (grant_o !== want || {grant_o, busy_o, value_o} !== {exp_grant, exp_busy, exp_value}) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: grant/value got %b/%h want %b/%h", c, grant_o, value_o, want, exp_value);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_value = 64'hD333_C222_B111_A000;
        req = 4'b0010;
        tick();
        req = 4'b1010;
        tick();
        req = 4'b1000;
        tick();
        n_vec++;
        if ({grant_o, busy_o} !== {4'b1000, 1'b1} || grant_o !== exp_grant) begin
            n_fail++;
            $display("FAIL early_release_grant: grant got %b want 1000", grant_o);
        end
        tick();
        n_vec++;
        if (value_o !== 16'hD333 || value_o !== exp_value) begin
            n_fail++;
            $display("FAIL early_release_value: value got %h want d333", value_o);
        end
    endtask

    task automatic test_expiry();
        logic [3:0] want;
        do_reset();
        req_value = 64'h0004_0003_0002_0001;
        req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) req = 4'b0101;
            tick();
            want = (c <= 4) ? 4'b0001 : 4'b0100;
            n_vec++;
            if (grant_o !== want || {grant_o, busy_o, value_o} !== {exp_grant, exp_busy, exp_value}) begin
                n_fail++;
                $display("FAIL expiry[%0d]: grant/value got %b/%h want %b/%h", c, grant_o, value_o, want, exp_value);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        n_vec++;
        if (grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_setup: grant got %b want 0010", grant_o);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({grant_o, busy_o, value_o} !== {4'b0000, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL mid_reset_clear: grant/busy/value got %b/%b/%h want 0000/0/0000", grant_o, busy_o, value_o);
        end
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (grant_o !== 4'b0010 || grant_o !== exp_grant) begin
            n_fail++;
            $display("FAIL mid_reset_regrant: grant got %b want 0010", grant_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        req = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            req_value = {$urandom, $urandom};
            tick();
            n_vec++;
            if ({grant_o, busy_o, value_o} !== {exp_grant, exp_busy, exp_value}) begin
                n_fail++;
                $display("FAIL random[%0d]: grant/busy/value got %b/%b/%h want %b/%b/%h", i, grant_o, busy_o, value_o, exp_grant, exp_busy, exp_value);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_expiry();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
